// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write scheduler.
// Holds the data/address widths, the register-address type shared with the
// register file, and the scheduler FSM state encoding.
package rf_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef enum logic [0:0] {
        StNormal,
        StDrain
    } sched_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for outstanding MUL/DIV operations.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   set_en, set_addr     mark a register pending (caller guarantees addr != 0)
//   clr_en, clr_addr     clear a register on MUL/DIV writeback (addr != 0)
//   rs1_addr, rs2_addr,
//   rd_addr              lookup addresses
//   eff_rs1, eff_rs2,
//   eff_rd               pending state with this cycle's clear already applied
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  reg_addr_t rd_addr,
    output logic      eff_rs1,
    output logic      eff_rs2,
    output logic      eff_rd
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] eff;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (clr_en) clr_vec[clr_addr] = 1'b1;
        if (set_en) set_vec[set_addr] = 1'b1;
        // The register file forwards the same-cycle write, so a clearing
        // register no longer blocks.
        eff     = pending_q & ~clr_vec;
        eff_rs1 = eff[rs1_addr];
        eff_rs2 = eff[rs2_addr];
        eff_rd  = eff[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            // Set wins over a clear of the same register; x0 is never pending.
            pending_q <= {eff[NUM_REGS-1:1] | set_vec[NUM_REGS-1:1], 1'b0};
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler.
// Shares the single write port between pipeline writeback (priority) and the
// MUL/DIV unit, tracks outstanding MUL/DIV destinations, and stalls issue on
// RAW/WAW hazards, MUL/DIV capacity, and while force-draining a starved
// MUL/DIV result.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   issue_*                          decode/issue instruction fields
//   wb_valid/wb_rd/wb_data, wb_accept pipeline writeback request/consume
//   md_valid/md_rd/md_data, md_ready  MUL/DIV result handshake
//   wr_rd_en/rd_address/rd_data      register file write port
//   pipe_stall                       freeze issue and writeback
//   err_underflow                    sticky: MUL/DIV result with none outstanding
module rf_write_scheduler
    import rf_pkg::*;
#(
    parameter int unsigned MD_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      issue_valid,
    input  logic      issue_long,
    input  reg_addr_t issue_rd,
    input  reg_addr_t issue_rs1_address,
    input  reg_addr_t issue_rs2_address,
    input  logic      issue_rs1_en,
    input  logic      issue_rs2_en,
    input  logic      wb_valid,
    input  reg_addr_t wb_rd,
    input  xlen_t     wb_data,
    output logic      wb_accept,
    input  logic      md_valid,
    input  reg_addr_t md_rd,
    input  xlen_t     md_data,
    output logic      md_ready,
    output logic      wr_rd_en,
    output reg_addr_t rd_address,
    output xlen_t     rd_data,
    output logic      pipe_stall,
    output logic      err_underflow
);

    localparam logic [2:0] DEPTH_C  = 3'(MD_DEPTH);
    localparam logic [3:0] AGE_MAX  = 4'(STARVE_LIMIT - 1);

    sched_state_e state_q;
    logic [2:0]   cnt_q;
    logic [2:0]   cnt_eff;
    logic [3:0]   age_q;

    logic md_hs;
    logic md_blocked;
    logic clr_en;
    logic set_en;
    logic issue_acc;
    logic long_acc;
    logic hazard;
    logic eff_rs1;
    logic eff_rs2;
    logic eff_rd;

    // Write-port arbitration; everything is held quiet during reset.
    always_comb begin
        wb_accept  = 1'b0;
        md_ready   = 1'b0;
        wr_rd_en   = 1'b0;
        rd_address = '0;
        rd_data    = '0;
        if (!reset) begin
            if (state_q == StNormal && wb_valid) begin
                wb_accept = 1'b1;
            end
            if (state_q == StNormal && wb_valid && wb_rd != '0) begin
                wr_rd_en   = 1'b1;
                rd_address = wb_rd;
                rd_data    = wb_data;
            end else begin
                md_ready = 1'b1;
                if (md_valid && md_rd != '0) begin
                    wr_rd_en   = 1'b1;
                    rd_address = md_rd;
                    rd_data    = md_data;
                end
            end
        end
    end

    assign md_hs      = md_valid & md_ready;
    assign md_blocked = md_valid & ~md_ready;
    assign clr_en     = md_hs & (md_rd != '0);
    assign cnt_eff    = (md_hs && cnt_q != '0) ? cnt_q - 3'd1 : cnt_q;

    assign hazard = issue_valid & ((issue_rs1_en & eff_rs1) | (issue_rs2_en & eff_rs2) | eff_rd |
                                   (issue_long & (cnt_eff == DEPTH_C)));

    assign pipe_stall = ~reset & (hazard | (state_q == StDrain));
    assign issue_acc  = ~reset & issue_valid & ~pipe_stall;
    assign long_acc   = issue_acc & issue_long;
    assign set_en     = long_acc & (issue_rd != '0);

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_addr (issue_rd),
        .clr_en   (clr_en),
        .clr_addr (md_rd),
        .rs1_addr (issue_rs1_address),
        .rs2_addr (issue_rs2_address),
        .rd_addr  (issue_rd),
        .eff_rs1  (eff_rs1),
        .eff_rs2  (eff_rs2),
        .eff_rd   (eff_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StNormal;
            cnt_q         <= '0;
            age_q         <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (long_acc && !md_hs) begin
                cnt_q <= cnt_q + 3'd1;
            end else if (md_hs && !long_acc && cnt_q != '0) begin
                cnt_q <= cnt_q - 3'd1;
            end

            if (md_hs && cnt_q == '0) begin
                err_underflow <= 1'b1;
            end

            unique case (state_q)
                StNormal: begin
                    if (md_blocked) begin
                        if (age_q == AGE_MAX) begin
                            state_q <= StDrain;
                            age_q   <= '0;
                        end else begin
                            age_q <= age_q + 4'd1;
                        end
                    end else begin
                        age_q <= '0;
                    end
                end
                StDrain: begin
                    age_q <= '0;
                    if (md_hs || !md_valid) state_q <= StNormal;
                end
                default: begin
                    state_q <= StNormal;
                    age_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed self-checking bench for rf_write_scheduler (MD_DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
module tb_rf_write_scheduler;
    import rf_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      issue_valid, issue_long, issue_rs1_en, issue_rs2_en;
    reg_addr_t issue_rd, issue_rs1_address, issue_rs2_address;
    logic      wb_valid, md_valid;
    reg_addr_t wb_rd, md_rd;
    xlen_t     wb_data, md_data;
    logic      wb_accept, md_ready, wr_rd_en, pipe_stall, err_underflow;
    reg_addr_t rd_address;
    xlen_t     rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_write_scheduler #(
        .MD_DEPTH     (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .issue_valid       (issue_valid),
        .issue_long        (issue_long),
        .issue_rd          (issue_rd),
        .issue_rs1_address (issue_rs1_address),
        .issue_rs2_address (issue_rs2_address),
        .issue_rs1_en      (issue_rs1_en),
        .issue_rs2_en      (issue_rs2_en),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .wb_accept         (wb_accept),
        .md_valid          (md_valid),
        .md_rd             (md_rd),
        .md_data           (md_data),
        .md_ready          (md_ready),
        .wr_rd_en          (wr_rd_en),
        .rd_address        (rd_address),
        .rd_data           (rd_data),
        .pipe_stall        (pipe_stall),
        .err_underflow     (err_underflow)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic issue(input logic v, input logic lng, input reg_addr_t rd,
                         input reg_addr_t rs1, input logic rs1_en);
        issue_valid       = v;
        issue_long        = lng;
        issue_rd          = rd;
        issue_rs1_address = rs1;
        issue_rs1_en      = rs1_en;
        issue_rs2_address = 5'd0;
        issue_rs2_en      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
        md_valid = 1'b0; md_rd = 5'd0; md_data = '0;
        tick();
        tick();

        // Outputs stay quiet while reset is held, even with requests present.
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1111;
        md_valid = 1'b1; md_rd = 5'd6;
        issue(1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        settle();
        chk1("rst_wr_en", wr_rd_en, 1'b0);
        chk1("rst_md_ready", md_ready, 1'b0);
        chk1("rst_wb_accept", wb_accept, 1'b0);
        chk1("rst_stall", pipe_stall, 1'b0);
        tick();
        reset = 1'b0;
        wb_valid = 1'b0; md_valid = 1'b0;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();

        // Idle.
        settle();
        chk1("idle_wr_en", wr_rd_en, 1'b0);
        chk1("idle_wb_accept", wb_accept, 1'b0);
        chk1("idle_stall", pipe_stall, 1'b0);
        chk1("idle_md_ready", md_ready, 1'b1);
        chk1("idle_err", err_underflow, 1'b0);

        // Pipeline writeback.
        tick();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
        settle();
        chk1("wb_wr_en", wr_rd_en, 1'b1);
        chk5("wb_addr", rd_address, 5'd5);
        chk32("wb_data", rd_data, 32'h0000_1234);
        chk1("wb_accept", wb_accept, 1'b1);
        chk1("wb_md_ready", md_ready, 1'b0);
        tick();
        wb_rd = 5'd0;
        settle();
        chk1("wb0_accept", wb_accept, 1'b1);
        chk1("wb0_wr_en", wr_rd_en, 1'b0);
        tick();
        wb_valid = 1'b0;

        // RAW on a pending MUL/DIV destination.
        issue(1'b1, 1'b1, 5'd7, 5'd0, 1'b0);
        settle();
        chk1("long7_accept", pipe_stall, 1'b0);
        tick();
        issue(1'b1, 1'b0, 5'd1, 5'd7, 1'b1);
        settle();
        chk1("raw_stall_a", pipe_stall, 1'b1);
        tick();
        settle();
        chk1("raw_stall_b", pipe_stall, 1'b1);
        tick();
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h0000_abcd;
        settle();
        chk1("raw_release", pipe_stall, 1'b0);
        chk1("md7_ready", md_ready, 1'b1);
        chk1("md7_wr_en", wr_rd_en, 1'b1);
        chk5("md7_addr", rd_address, 5'd7);
        chk32("md7_data", rd_data, 32'h0000_abcd);
        tick();
        md_valid = 1'b0;
        issue(1'b1, 1'b1, 5'd9, 5'd0, 1'b0);
        tick();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

        // Writeback has priority; MUL/DIV goes next cycle.
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
        settle();
        chk5("prio_wb_addr", rd_address, 5'd3);
        chk32("prio_wb_data", rd_data, 32'h33);
        chk1("prio_md_ready", md_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        settle();
        chk1("prio_md_ready2", md_ready, 1'b1);
        chk5("prio_md_addr", rd_address, 5'd9);
        chk32("prio_md_data", rd_data, 32'h99);
        tick();
        md_valid = 1'b0;
        settle();
        chk1("no_underflow", err_underflow, 1'b0);

        // Starvation: 4 blocked cycles, then one forced-drain cycle.
        tick();
        issue(1'b1, 1'b1, 5'd10, 5'd0, 1'b0);
        tick();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        md_valid = 1'b1; md_rd = 5'd10; md_data = 32'ha0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("starve_md_ready", md_ready, 1'b0);
            chk1("starve_stall", pipe_stall, 1'b0);
            tick();
        end
        settle();
        chk1("drain_stall", pipe_stall, 1'b1);
        chk1("drain_wb_accept", wb_accept, 1'b0);
        chk1("drain_md_ready", md_ready, 1'b1);
        chk5("drain_addr", rd_address, 5'd10);
        chk32("drain_data", rd_data, 32'ha0);
        tick();
        md_valid = 1'b0;
        settle();
        chk1("post_drain_stall", pipe_stall, 1'b0);
        chk1("post_drain_accept", wb_accept, 1'b1);
        chk5("post_drain_addr", rd_address, 5'd4);
        tick();
        wb_valid = 1'b0;

        // Capacity: MD_DEPTH=2.
        issue(1'b1, 1'b1, 5'd11, 5'd0, 1'b0);
        tick();
        issue(1'b1, 1'b1, 5'd12, 5'd0, 1'b0);
        tick();
        issue(1'b1, 1'b1, 5'd13, 5'd0, 1'b0);
        settle();
        chk1("cap_stall", pipe_stall, 1'b1);
        tick();
        md_valid = 1'b1; md_rd = 5'd11; md_data = 32'hb1;
        settle();
        chk1("cap_hs_accept", pipe_stall, 1'b0);
        tick();
        md_valid = 1'b0;
        issue(1'b1, 1'b1, 5'd14, 5'd0, 1'b0);
        settle();
        chk1("cap_cnt_held", pipe_stall, 1'b1);

        // Mid-stall reset.
        reset = 1'b1;
        settle();
        chk1("rst_mid_stall", pipe_stall, 1'b0);
        tick();
        reset = 1'b0;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();

        // Underflow: handshake with nothing outstanding.
        md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h55;
        settle();
        chk1("uf_md_ready", md_ready, 1'b1);
        tick();
        md_valid = 1'b0;
        settle();
        chk1("uf_err", err_underflow, 1'b1);
        tick();
        settle();
        chk1("uf_sticky", err_underflow, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk1("uf_reset_clears", err_underflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
